// File: rtl/cfg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// cfg_pkg : shared constants and FIFO entry type for config_streamer
// Rev 1.0
// ----------------------------------------------------------------------
package cfg_pkg;

  localparam logic [31:0] NOP_ADDR    = 32'h0000_0000;
  localparam int          TILE_ID_LSB = 0;
  localparam int          TILE_ID_MSB = 15;
  localparam int          MOD_ID_LSB  = 16;
  localparam int          MOD_ID_MSB  = 31;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } cfg_entry_t;

endpackage
`default_nettype wire

// File: rtl/cfg_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// cfg_fifo : synchronous FIFO of cfg_entry_t with full/empty flags
// Rev 1.0
// ----------------------------------------------------------------------
module cfg_fifo
  import cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  cfg_entry_t push_entry,
  input  logic       pop,
  output cfg_entry_t pop_entry,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  cfg_entry_t      r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_entry;
  end

  // Extra pointer MSB distinguishes a wrapped (full) FIFO from an empty one.
  assign pop_entry = r_mem[r_rd_ptr[AW-1:0]];
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/config_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------
// config_streamer : host addr/data word stream -> held tile config writes
// Rev 1.0
// ----------------------------------------------------------------------
module config_streamer
  import cfg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        in_last,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] writes
);

  localparam logic       EXP_ADDR  = 1'b0;
  localparam logic       EXP_DATA  = 1'b1;
  localparam logic       D_IDLE    = 1'b0;
  localparam logic       D_DRIVE   = 1'b1;
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  logic        r_asm_state;
  logic        w_asm_next;
  logic [31:0] r_pend_addr;
  logic        r_drv_state;
  logic        w_drv_next;
  logic [3:0]  r_hold_cnt;
  logic        r_cur_last;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_data;
  logic        r_done;
  logic [15:0] r_writes;

  logic        w_accept;
  logic        w_nop_pair;
  logic        w_push;
  logic        w_drop_last;
  logic        w_pop;
  logic        w_hold_done;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  cfg_entry_t  w_push_entry;
  cfg_entry_t  w_head;

  assign w_accept     = in_valid && in_ready;
  assign w_nop_pair   = (r_pend_addr[MOD_ID_MSB:MOD_ID_LSB] == 16'h0000);
  assign w_push_entry = '{addr: r_pend_addr, data: in_word, last: in_last};

  cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .pop_entry  (w_head),
    .full       (w_fifo_full),
    .empty      (w_fifo_empty)
  );

  // Assembler: state register / next state / outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_asm_state <= EXP_ADDR;
    else       r_asm_state <= w_asm_next;
  end

  always_comb begin
    w_asm_next = r_asm_state;
    if (w_accept) w_asm_next = (r_asm_state == EXP_ADDR) ? EXP_DATA : EXP_ADDR;
  end

  always_comb begin
    in_ready    = (r_asm_state == EXP_ADDR) || !w_fifo_full;
    w_push      = (r_asm_state == EXP_DATA) && w_accept && !w_nop_pair;
    w_drop_last = (r_asm_state == EXP_DATA) && w_accept && w_nop_pair && in_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_pend_addr <= '0;
    else if ((r_asm_state == EXP_ADDR) && w_accept) r_pend_addr <= in_word;
  end

  // Driver: state register / next state / outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_drv_state <= D_IDLE;
    else       r_drv_state <= w_drv_next;
  end

  always_comb begin
    w_drv_next = r_drv_state;
    if (r_drv_state == D_IDLE) begin
      if (!w_fifo_empty) w_drv_next = D_DRIVE;
    end else if (w_hold_done && w_fifo_empty) begin
      w_drv_next = D_IDLE;
    end
  end

  always_comb begin
    w_hold_done = (r_drv_state == D_DRIVE) && (r_hold_cnt == 4'd0);
    w_pop       = !w_fifo_empty && ((r_drv_state == D_IDLE) || w_hold_done);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_addr <= NOP_ADDR;
      r_bus_data <= '0;
      r_hold_cnt <= '0;
      r_cur_last <= 1'b0;
      r_writes   <= '0;
      r_done     <= 1'b0;
    end else begin
      // A completing write chains straight into the next entry with no NOP gap.
      if (w_pop) begin
        r_bus_addr <= w_head.addr;
        r_bus_data <= w_head.data;
        r_cur_last <= w_head.last;
        r_hold_cnt <= HOLD_INIT;
      end else if (w_hold_done) begin
        r_bus_addr <= NOP_ADDR;
        r_bus_data <= '0;
        r_cur_last <= 1'b0;
      end else if (r_drv_state == D_DRIVE) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      if (w_hold_done && (r_writes != 16'hFFFF)) r_writes <= r_writes + 16'd1;
      r_done <= (w_hold_done && r_cur_last) || w_drop_last;
    end
  end

  assign config_addr = r_bus_addr;
  assign config_data = r_bus_data;
  assign writes      = r_writes;
  assign done        = r_done;
  assign busy        = (r_asm_state == EXP_DATA) || !w_fifo_empty || (r_drv_state == D_DRIVE);

endmodule
`default_nettype wire
